f1_lights_out_timer: RTL and testbench

Downstream stage of the F1 start-light sequencer. It watches for the "all lights on" condition (8'hFF) and then waits a pseudo-random number of ticks before signalling lights-out. After lights-out it measures the player's reaction time in ticks and flags jump starts. It shares the sequencer's clk and rst and its one-cycle tick enable.

---
 rtl/f1_pkg.sv | 20 ++
 rtl/f1_lfsr7.sv | 29 ++
 rtl/f1_lights_out_timer.sv | 127 ++++++++++++
 tb/tb_f1_lights_out_timer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 lights-out timer.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    REACT = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_e;

  localparam logic [7:0] LIGHTS_FULL = 8'hFF;
  localparam logic [6:0] LFSR_SEED   = 7'h01;

  // Maximal-length 7-bit Fibonacci step (taps 7,6); never reaches zero from a non-zero seed.
  function automatic logic [6:0] lfsr7_next(input logic [6:0] cur);
    return {cur[5:0], cur[6] ^ cur[5]};
  endfunction

endpackage

// File: rtl/f1_lfsr7.sv
// Free-running 7-bit LFSR, period 127, seeded on reset.
module f1_lfsr7
  import f1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] q
);

  logic [6:0] q_q;
  logic [6:0] q_d;

  // Advance every clock; randomness comes from when the lights happen to fill.
  always_comb begin
    q_d = lfsr7_next(q_q);
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/f1_lights_out_timer.sv
// F1 lights-out timer: after all lights are on, waits a pseudo-random number of ticks,
// pulses lights_out, then measures reaction time in ticks and flags jump starts.
// Build option: define DEBUG_FIXED_DELAY_EN to load FIXED_DELAY instead of a random delay.
module f1_lights_out_timer
  import f1_pkg::*;
#(
  parameter int unsigned MIN_DELAY   = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FIXED_DELAY = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [7:0]       lights,
  input  logic             button,
  output logic             lights_out,
  output logic [CNT_W-1:0] react_time,
  output logic             react_valid,
  output logic             jump_start,
  output logic             busy
);

`ifdef DEBUG_FIXED_DELAY_EN
  localparam bit UseFixedDelay = 1'b1;
`else
  localparam bit UseFixedDelay = 1'b0;
`endif

  localparam logic [7:0] MinLoad = 8'(MIN_DELAY);
  localparam logic [7:0] FixLoad = 8'(FIXED_DELAY);

  state_e           state_q, state_d;
  logic             full_q;
  logic [7:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] react_time_q, react_time_d;
  logic             lights_out_q, lights_out_d;
  logic [6:0]       lfsr_q;
  logic             full;
  logic [7:0]       delay_load;

  f1_lfsr7 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign full       = (lights == LIGHTS_FULL);
  // Max random load is MIN_DELAY + 127, which fits in 8 bits for the default MIN_DELAY.
  assign delay_load = UseFixedDelay ? FixLoad : (MinLoad + {1'b0, lfsr_q});

  // Next-state, counter and result logic for the start/reaction sequence.
  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    rcnt_d       = rcnt_q;
    react_time_d = react_time_q;
    lights_out_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (full && !full_q) begin
          dcnt_d  = delay_load;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (!full) begin
          state_d = IDLE;
        end else if (button) begin
          state_d = FAULT;
        end else if (tick) begin
          // A zero load expires on the first tick just like a load of one.
          if (dcnt_q <= 8'd1) begin
            state_d      = REACT;
            lights_out_d = 1'b1;
            rcnt_d       = '0;
          end else begin
            dcnt_d = dcnt_q - 8'd1;
          end
        end
      end
      REACT: begin
        if (!full) begin
          state_d = IDLE;
        end else if (button) begin
          state_d      = DONE;
          react_time_d = rcnt_q;
        end else if (tick && (rcnt_q != {CNT_W{1'b1}})) begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!full) state_d = IDLE;
      end
      FAULT: begin
        if (!full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      full_q       <= 1'b0;
      dcnt_q       <= '0;
      rcnt_q       <= '0;
      react_time_q <= '0;
      lights_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full;
      dcnt_q       <= dcnt_d;
      rcnt_q       <= rcnt_d;
      react_time_q <= react_time_d;
      lights_out_q <= lights_out_d;
    end
  end

  assign lights_out  = lights_out_q;
  assign react_time  = react_time_q;
  assign react_valid = (state_q == DONE);
  assign jump_start  = (state_q == FAULT);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_f1_lights_out_timer.sv
// Directed self-checking bench for f1_lights_out_timer (works with or without
// DEBUG_FIXED_DELAY_EN; expected delays come from a local LFSR model or the fixed value).
module tb_f1_lights_out_timer;

  localparam int MIN_D = 8;
  localparam int FIX   = 3;
`ifdef DEBUG_FIXED_DELAY_EN
  localparam int D_LO = FIX;
  localparam int D_HI = FIX;
`else
  localparam int D_LO = 8;
  localparam int D_HI = 135;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [7:0]  lights;
  logic        button;
  logic        lights_out;
  logic [15:0] react_time;
  logic        react_valid;
  logic        jump_start;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int period = 4;
  int tphase = 0;

  logic [6:0] lfsr_m;

  f1_lights_out_timer #(
    .MIN_DELAY   (MIN_D),
    .CNT_W       (16),
    .FIXED_DELAY (FIX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .lights      (lights),
    .button      (button),
    .lights_out  (lights_out),
    .react_time  (react_time),
    .react_valid (react_valid),
    .jump_start  (jump_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR, stepped on the same clock and reset as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 7'h01;
    else     lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
  end

  function automatic int exp_delay(input logic [6:0] l);
    int r;
    r = MIN_D + int'(l);
`ifdef DEBUG_FIXED_DELAY_EN
    r = FIX;
`endif
    return r;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    tphase = (tphase + 1) % period;
    tick   = (tphase == 0);
  endtask

  // Count ticks presented while waiting for the lights_out pulse (bounded).
  task automatic wait_lights_out(output int nt, output bit seen);
    nt   = 0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (tick) nt++;
      cyc();
      if (lights_out) seen = 1'b1;
    end
  endtask

  task automatic count_ticks(input int n);
    int c;
    c = 0;
    for (int i = 0; i < 1000 && c < n; i++) begin
      if (tick) c++;
      cyc();
    end
  endtask

  task automatic test_reset();
    n_chk++;
    if ({busy, lights_out, react_valid, jump_start} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {busy, lights_out, react_valid, jump_start});
    end
    n_chk++;
    if (react_time !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_time: got %h want 0000", react_time);
    end
    rst = 1'b0;
    cyc();
    cyc();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_delay();
    int d, nt;
    bit seen;
    period = 4;
    d = exp_delay(lfsr_m);
    lights = 8'hFF;
    cyc();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL delay_busy: got %b want 1", busy);
    end
    wait_lights_out(nt, seen);
    n_chk++;
    if (!seen || nt != d) begin
      n_fail++;
      $display("FAIL delay_ticks: got seen=%0b ticks=%0d want seen=1 ticks=%0d", seen, nt, d);
    end
    cyc();
    n_chk++;
    if (lights_out !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_width: got lo=%b busy=%b want lo=0 busy=1", lights_out, busy);
    end
    // Dropping the lights in REACT aborts without a result.
    lights = 8'h00;
    cyc();
    n_chk++;
    if (busy !== 1'b0 || react_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got busy=%b valid=%b want 0 0", busy, react_valid);
    end
  endtask

  task automatic test_reaction();
    int nt;
    bit seen;
    period = 4;
    lights = 8'hFF;
    cyc();
    wait_lights_out(nt, seen);
    // Five ticks counted in REACT, then a press on a non-tick cycle.
    count_ticks(5);
    button = 1'b1;
    cyc();
    button = 1'b0;
    n_chk++;
    if (react_valid !== 1'b1 || react_time !== 16'd5) begin
      n_fail++;
      $display("FAIL react_result: got valid=%b time=%0d want valid=1 time=5",
               react_valid, react_time);
    end
    repeat (10) cyc();
    n_chk++;
    if (react_valid !== 1'b1 || react_time !== 16'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL react_hold: got valid=%b time=%0d busy=%b want 1 5 1",
               react_valid, react_time, busy);
    end
    lights = 8'h00;
    cyc();
    n_chk++;
    if (react_valid !== 1'b0 || busy !== 1'b0 || react_time !== 16'd5) begin
      n_fail++;
      $display("FAIL react_clear: got valid=%b busy=%b time=%0d want 0 0 5",
               react_valid, busy, react_time);
    end
  endtask

  task automatic test_jump_start();
    bit seen_lo;
    period = 4;
    lights = 8'hFF;
    cyc();
    count_ticks(1);
    for (int i = 0; i < 8 && !tick; i++) cyc();
    button = 1'b1;
    cyc();
    button = 1'b0;
    n_chk++;
    if (jump_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_set: got js=%b busy=%b want 1 1", jump_start, busy);
    end
    seen_lo = 1'b0;
    for (int i = 0; i < 700; i++) begin
      cyc();
      if (lights_out) seen_lo = 1'b1;
    end
    n_chk++;
    if (seen_lo !== 1'b0 || jump_start !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_hold: got pulse=%b js=%b want 0 1", seen_lo, jump_start);
    end
    lights = 8'h00;
    cyc();
    n_chk++;
    if (jump_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_clear: got js=%b busy=%b want 0 0", jump_start, busy);
    end
  endtask

  task automatic test_random();
    int d, nt;
    bit seen;
    period = 2;
    for (int r = 0; r < 20; r++) begin
      repeat (r * 3 + 1) cyc();
      d = exp_delay(lfsr_m);
      lights = 8'hFF;
      cyc();
      wait_lights_out(nt, seen);
      n_chk++;
      if (!seen || nt != d || nt < D_LO || nt > D_HI) begin
        n_fail++;
        $display("FAIL random_delay[%0d]: got seen=%0b ticks=%0d want ticks=%0d in %0d..%0d",
                 r, seen, nt, d, D_LO, D_HI);
      end
      lights = 8'h00;
      cyc();
    end
  endtask

  task automatic test_saturate();
    int nt;
    bit seen;
    period = 1;
    lights = 8'hFF;
    cyc();
    wait_lights_out(nt, seen);
    repeat (70000) cyc();
    button = 1'b1;
    cyc();
    button = 1'b0;
    n_chk++;
    if (react_valid !== 1'b1 || react_time !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturate: got valid=%b time=%h want 1 ffff", react_valid, react_time);
    end
    lights = 8'h00;
    cyc();
  endtask

  task automatic test_reset_mid();
    int d, nt;
    bit seen;
    period = 4;
    lights = 8'hFF;
    cyc();
    repeat (5) cyc();
    rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, lights_out, react_valid, jump_start} !== 4'b0 || react_time !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_delay: got flags=%b time=%h want 0000 0000",
               {busy, lights_out, react_valid, jump_start}, react_time);
    end
    lights = 8'h00;
    cyc();
    rst = 1'b0;
    cyc();
    lights = 8'hFF;
    cyc();
    wait_lights_out(nt, seen);
    count_ticks(2);
    button = 1'b1;
    cyc();
    button = 1'b0;
    n_chk++;
    if (react_valid !== 1'b1 || react_time !== 16'd2) begin
      n_fail++;
      $display("FAIL pre_rst_done: got valid=%b time=%0d want 1 2", react_valid, react_time);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, lights_out, react_valid, jump_start} !== 4'b0 || react_time !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_done: got flags=%b time=%h want 0000 0000",
               {busy, lights_out, react_valid, jump_start}, react_time);
    end
    lights = 8'h00;
    cyc();
    rst = 1'b0;
    cyc();
    d = exp_delay(lfsr_m);
    lights = 8'hFF;
    cyc();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_busy: got %b want 1", busy);
    end
    wait_lights_out(nt, seen);
    n_chk++;
    if (!seen || nt != d) begin
      n_fail++;
      $display("FAIL restart_delay: got seen=%0b ticks=%0d want seen=1 ticks=%0d", seen, nt, d);
    end
    lights = 8'h00;
    cyc();
  endtask

  initial begin
    rst    = 1'b1;
    tick   = 1'b0;
    lights = 8'h00;
    button = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_delay();
    test_reaction();
    test_jump_start();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
